mem_stage: RTL and testbench

MEM_STAGE -- requirements
Module: mem_stage

---
 rtl/mem_stage.sv | 147 ++++++++++++++
 tb/tb_mem_stage.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
// EX/MEM pipeline register, data-memory access FSM and MEM/WB register.
// Optional access timeout is enabled by defining MEM_TIMEOUT_EN.
module mem_stage #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_valid,
  input  logic        ex_reg_write,
  input  logic        ex_mem_read,
  input  logic        ex_mem_write,
  input  logic [31:0] ex_alu_result,
  input  logic [31:0] ex_store_data,
  input  logic [4:0]  ex_rd,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ready,
  output logic        mem_stall,
  output logic        wb_valid,
  output logic        wb_reg_write,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        fwd_mem_valid,
  output logic [4:0]  fwd_mem_rd,
  output logic [31:0] fwd_mem_data,
  output logic        mem_err
);

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t      state;
  logic        m_valid;
  logic        m_reg_write;
  logic        m_mem_read;
  logic        m_mem_write;
  logic [31:0] m_alu_result;
  logic [31:0] m_store_data;
  logic [4:0]  m_rd;

  logic access;
  logic ex_is_mem;
  logic m_is_mem;
  logic m_is_store;
  logic m_rd_write;
  logic timeout_hit;

  assign access     = (state == ACCESS);
  assign ex_is_mem  = ex_valid & (ex_mem_read | ex_mem_write);
  assign m_is_mem   = m_mem_read | m_mem_write;
  // Read+write together is treated as a load, so only a pure write stores.
  assign m_is_store = m_mem_write & ~m_mem_read;
  assign m_rd_write = m_valid & m_reg_write & (m_rd != 5'd0);

  assign mem_stall  = access & ~dmem_ready;
  assign dmem_req   = access;
  assign dmem_we    = access & m_is_store;
  assign dmem_addr  = access ? m_alu_result : 32'd0;
  assign dmem_wdata = access ? m_store_data : 32'd0;

  assign fwd_mem_valid = m_rd_write & ~m_mem_read;
  assign fwd_mem_rd    = m_rd;
  assign fwd_mem_data  = m_alu_result;

`ifdef MEM_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] wait_count;
  logic          err_flag;

  assign timeout_hit = mem_stall & (wait_count == CW'(TIMEOUT_CYCLES - 1));
  assign mem_err     = err_flag;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_count <= '0;
      err_flag   <= 1'b0;
    end else if (timeout_hit) begin
      wait_count <= '0;
      err_flag   <= 1'b1;
    end else if (mem_stall) begin
      wait_count <= wait_count + 1'b1;
    end else begin
      wait_count <= '0;
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign mem_err     = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      m_valid      <= 1'b0;
      m_reg_write  <= 1'b0;
      m_mem_read   <= 1'b0;
      m_mem_write  <= 1'b0;
      m_alu_result <= 32'd0;
      m_store_data <= 32'd0;
      m_rd         <= 5'd0;
      wb_valid     <= 1'b0;
      wb_reg_write <= 1'b0;
      wb_rd        <= 5'd0;
      wb_data      <= 32'd0;
    end else begin
      if (!mem_stall) begin
        m_valid      <= ex_valid;
        m_reg_write  <= ex_reg_write;
        m_mem_read   <= ex_mem_read;
        m_mem_write  <= ex_mem_write;
        m_alu_result <= ex_alu_result;
        m_store_data <= ex_store_data;
        m_rd         <= ex_rd;
      end

      // A memory op left in m while IDLE (after an abort) must not retire twice.
      if (!access) begin
        wb_valid     <= m_valid & ~m_is_mem;
        wb_reg_write <= m_rd_write & ~m_is_mem;
        wb_rd        <= m_rd;
        wb_data      <= m_alu_result;
      end else if (dmem_ready) begin
        wb_valid     <= m_valid;
        wb_reg_write <= m_rd_write & ~m_is_store;
        wb_rd        <= m_rd;
        wb_data      <= m_mem_read ? dmem_rdata : m_alu_result;
      end else if (timeout_hit) begin
        wb_valid     <= m_valid;
        wb_reg_write <= 1'b0;
        wb_rd        <= m_rd;
        wb_data      <= m_alu_result;
      end else begin
        wb_valid     <= 1'b0;
        wb_reg_write <= 1'b0;
      end

      if (timeout_hit) begin
        state <= IDLE;
      end else if (!mem_stall) begin
        state <= ex_is_mem ? ACCESS : IDLE;
      end
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Directed self-checking bench for mem_stage with a small word-addressed memory model.
// Timeout scenario is compiled in only when MEM_TIMEOUT_EN is defined.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        ex_valid = 1'b0;
  logic        ex_reg_write = 1'b0;
  logic        ex_mem_read = 1'b0;
  logic        ex_mem_write = 1'b0;
  logic [31:0] ex_alu_result = 32'd0;
  logic [31:0] ex_store_data = 32'd0;
  logic [4:0]  ex_rd = 5'd0;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [31:0] dmem_rdata;
  logic        dmem_ready = 1'b0;
  logic        mem_stall;
  logic        wb_valid;
  logic        wb_reg_write;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        fwd_mem_valid;
  logic [4:0]  fwd_mem_rd;
  logic [31:0] fwd_mem_data;
  logic        mem_err;

  int n_checks = 0;
  int n_fail   = 0;

  mem_stage #(.TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst(rst),
    .ex_valid(ex_valid), .ex_reg_write(ex_reg_write),
    .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
    .ex_alu_result(ex_alu_result), .ex_store_data(ex_store_data), .ex_rd(ex_rd),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_rdata(dmem_rdata), .dmem_ready(dmem_ready), .mem_stall(mem_stall),
    .wb_valid(wb_valid), .wb_reg_write(wb_reg_write), .wb_rd(wb_rd), .wb_data(wb_data),
    .fwd_mem_valid(fwd_mem_valid), .fwd_mem_rd(fwd_mem_rd), .fwd_mem_data(fwd_mem_data),
    .mem_err(mem_err)
  );

  always #5 clk = ~clk;

  // Memory model: word 0x40 preloaded with 0xDEADBEEF, writes complete with dmem_ready.
  logic [31:0] mem [0:63];
  logic [63:0] written = 64'd0;
  always @(posedge clk) begin
    if (dmem_req && dmem_we && dmem_ready) begin
      mem[dmem_addr[7:2]]     <= dmem_wdata;
      written[dmem_addr[7:2]] <= 1'b1;
    end
  end
  assign dmem_rdata = written[dmem_addr[7:2]] ? mem[dmem_addr[7:2]] :
                      (dmem_addr[7:2] == 6'd16) ? 32'hDEADBEEF : 32'd0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic rw, input logic rd_en, input logic wr_en,
                       input logic [31:0] alu, input logic [31:0] sd, input logic [4:0] rd);
    ex_valid      = v;
    ex_reg_write  = rw;
    ex_mem_read   = rd_en;
    ex_mem_write  = wr_en;
    ex_alu_result = alu;
    ex_store_data = sd;
    ex_rd         = rd;
  endtask

  task automatic nop();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 5'd0);
  endtask

  initial begin
    #2 rst = 1'b1;
    #1;
    $display("[%0t] reset asserted", $time);
    check("rst_wb_valid", wb_valid, 0);
    check("rst_wb_reg_write", wb_reg_write, 0);
    check("rst_wb_data", wb_data, 0);
    check("rst_dmem_req", dmem_req, 0);
    check("rst_mem_stall", mem_stall, 0);
    check("rst_fwd_valid", fwd_mem_valid, 0);
    check("rst_mem_err", mem_err, 0);
    #8 rst = 1'b0;
    step();

    // ALU op r2 = 10
    $display("[%0t] alu op rd=2 value=10", $time);
    drive(1'b1, 1'b1, 1'b0, 1'b0, 32'd10, 32'd0, 5'd2);
    step();
    nop();
    check("alu_fwd_valid", fwd_mem_valid, 1);
    check("alu_fwd_rd", fwd_mem_rd, 2);
    check("alu_fwd_data", fwd_mem_data, 10);
    check("alu_wb_early", wb_valid, 0);
    check("alu_no_req", dmem_req, 0);
    step();
    check("alu_wb_valid", wb_valid, 1);
    check("alu_wb_rd", wb_rd, 2);
    check("alu_wb_data", wb_data, 10);
    check("alu_wb_rw", wb_reg_write, 1);
    check("alu_fwd_clear", fwd_mem_valid, 0);

    // ALU op with rd = 0
    $display("[%0t] alu op rd=0 value=5", $time);
    drive(1'b1, 1'b1, 1'b0, 1'b0, 32'd5, 32'd0, 5'd0);
    step();
    nop();
    check("rd0_fwd_valid", fwd_mem_valid, 0);
    step();
    check("rd0_wb_valid", wb_valid, 1);
    check("rd0_wb_rw", wb_reg_write, 0);
    check("rd0_wb_data", wb_data, 5);

    // Load 0x40 with three wait cycles
    $display("[%0t] load rd=3 addr=0x40, ready after 3 cycles", $time);
    dmem_ready = 1'b0;
    drive(1'b1, 1'b1, 1'b1, 1'b0, 32'h40, 32'd0, 5'd3);
    step();
    nop();
    check("ld_req", dmem_req, 1);
    check("ld_we", dmem_we, 0);
    check("ld_addr", dmem_addr, 32'h40);
    check("ld_fwd_valid", fwd_mem_valid, 0);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("ld_stall_%0d", i), mem_stall, 1);
      step();
      check($sformatf("ld_bubble_%0d", i), wb_valid, 0);
    end
    dmem_ready = 1'b1;
    #1;
    check("ld_stall_released", mem_stall, 0);
    check("ld_req_held", dmem_req, 1);
    step();
    dmem_ready = 1'b0;
    check("ld_wb_valid", wb_valid, 1);
    check("ld_wb_rd", wb_rd, 3);
    check("ld_wb_data", wb_data, 32'hDEADBEEF);
    check("ld_wb_rw", wb_reg_write, 1);
    check("ld_idle", dmem_req, 0);

    // Store 0x44 then load 0x44 back-to-back, zero-wait memory
    $display("[%0t] store 0x1234 to 0x44 then load rd=6 from 0x44", $time);
    dmem_ready = 1'b1;
    drive(1'b1, 1'b1, 1'b0, 1'b1, 32'h44, 32'h1234, 5'd5);
    step();
    drive(1'b1, 1'b1, 1'b1, 1'b0, 32'h44, 32'd0, 5'd6);
    #1;
    check("st_req", dmem_req, 1);
    check("st_we", dmem_we, 1);
    check("st_addr", dmem_addr, 32'h44);
    check("st_wdata", dmem_wdata, 32'h1234);
    check("st_stall", mem_stall, 0);
    step();
    nop();
    check("st_wb_valid", wb_valid, 1);
    check("st_wb_rw", wb_reg_write, 0);
    check("b2b_req", dmem_req, 1);
    check("b2b_we", dmem_we, 0);
    step();
    check("b2b_wb_valid", wb_valid, 1);
    check("b2b_wb_rd", wb_rd, 6);
    check("b2b_wb_data", wb_data, 32'h1234);
    check("b2b_wb_rw", wb_reg_write, 1);
    check("b2b_idle", dmem_req, 0);

    // Read and write both set behaves as a load
    $display("[%0t] read+write op rd=7 addr=0x40", $time);
    drive(1'b1, 1'b1, 1'b1, 1'b1, 32'h40, 32'h5555, 5'd7);
    step();
    nop();
    check("rw_req", dmem_req, 1);
    check("rw_we", dmem_we, 0);
    step();
    check("rw_wb_data", wb_data, 32'hDEADBEEF);
    check("rw_wb_rw", wb_reg_write, 1);

    // Reset in the middle of an access
    $display("[%0t] load rd=8 interrupted by reset", $time);
    dmem_ready = 1'b0;
    drive(1'b1, 1'b1, 1'b1, 1'b0, 32'h40, 32'd0, 5'd8);
    step();
    nop();
    check("abort_req_before", dmem_req, 1);
    step();
    #2 rst = 1'b1;
    #1;
    check("abort_req", dmem_req, 0);
    check("abort_stall", mem_stall, 0);
    check("abort_wb_valid", wb_valid, 0);
    check("abort_wb_data", wb_data, 0);
    rst = 1'b0;
    dmem_ready = 1'b1;
    step();
    check("abort_idle", dmem_req, 0);
    check("abort_no_wb", wb_valid, 0);
    step();
    check("abort_no_wb2", wb_valid, 0);
    dmem_ready = 1'b0;

`ifdef MEM_TIMEOUT_EN
    begin
      int stall_cycles;
      $display("[%0t] load rd=9 with dmem_ready held low (timeout)", $time);
      drive(1'b1, 1'b1, 1'b1, 1'b0, 32'h40, 32'd0, 5'd9);
      step();
      nop();
      stall_cycles = 0;
      while (mem_stall && stall_cycles < 40) begin
        stall_cycles++;
        step();
      end
      check("to_stall_cycles", stall_cycles, 16);
      check("to_idle", dmem_req, 0);
      check("to_mem_err", mem_err, 1);
      check("to_wb_valid", wb_valid, 1);
      check("to_wb_rw", wb_reg_write, 0);
      step();
      check("to_err_sticky", mem_err, 1);
      #2 rst = 1'b1;
      #1;
      check("to_err_reset", mem_err, 0);
      rst = 1'b0;
      step();
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
